pep9_apb_master: RTL
====================

Name: pep9_apb_master

Overview:
APB requester that turns single-byte memory requests from the Pep9 CPU datapath into APB3 Setup/Access transfers on the memory bus. It drives the bus that the APB memory slave responds to. Each transfer returns a one-cycle response carrying read data and an error flag. A programmable wait-state timeout stops a hung slave from stalling the CPU forever.

Parameters:
ADDR_W, 16, APB address width (PAddr, ReqAddr).
DATA_W, 8, APB data width (PWData, PRData, ReqWData, RspRData).
TIMEOUT, 255, maximum wait cycles tolerated in ACCESS with PReady=0; 0 disables the timeout.

Ports:
PClk  in  1  clock; all logic is rising-edge.
PResetn  in  1  asynchronous active-low reset.
ReqValid  in  1  CPU request valid.
ReqReady  out  1  master can accept a request (high only in IDLE).
ReqWrite  in  1  1 = write, 0 = read.
ReqAddr  in  ADDR_W  request byte address.
ReqWData  in  DATA_W  write data.
RspValid  out  1  one-cycle pulse: transfer finished.
RspRData  out  DATA_W  read data, valid while RspValid=1.
RspErr  out  1  timeout abort, valid while RspValid=1.
PAddr  out  ADDR_W  APB address.
PSelx  out  1  APB select.
PEnable  out  1  APB enable.
PWrite  out  1  APB direction.
PWData  out  DATA_W  APB write data.
PReady  in  1  APB slave ready.
PRData  in  DATA_W  APB read data.

Behaviour:
- Reset is asynchronous and active-low: PResetn low puts the master in IDLE immediately.
- Reset values: state=IDLE; PSelx=0, PEnable=0, PWrite=0, PAddr=0, PWData=0; RspValid=0, RspRData=0, RspErr=0; wait counter=0.
- ReqReady is combinational: equal to (state==IDLE).
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - PSelx=0, PEnable=0.
  - On ReqValid&&ReqReady: register ReqAddr/ReqWrite/ReqWData into PAddr/PWrite/PWData, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (exactly 1 cycle):
  - PSelx=1, PEnable=0.
  - Next state is always ACCESS.
- ACCESS:
  - PSelx=1, PEnable=1.
  - PAddr, PWrite and PWData hold stable for the whole access phase.
  - PReady=1 sampled: go to IDLE; next cycle RspValid=1, RspErr=0, RspRData=PRData on reads; RspRData=0 on writes.
  - PReady=0: increment the wait counter.
  - TIMEOUT!=0 and counter==TIMEOUT with PReady still 0: go to IDLE; next cycle RspValid=1, RspErr=1, RspRData=0.
  - The wait counter clears on every entry to SETUP.
- Counter width is $clog2(TIMEOUT+1), minimum 1. The counter saturates and never wraps.
- Latency, zero-wait slave: accept edge → SETUP → ACCESS → RspValid in the IDLE cycle. That is 3 cycles from the accept edge to RspValid.
- Each wait state adds 1 cycle of latency.
- RspValid is high for exactly one cycle per accepted request and never without one.
- Back-to-back: in the RspValid cycle the state is IDLE and ReqReady=1, so a new request can be accepted that same cycle.
- Sustained throughput is 1 transfer per 3 cycles.
- ReqValid while not in IDLE is ignored: not queued, no side effects. The CPU must hold ReqValid until it sees ReqReady.
- Outside a transfer, PAddr/PWrite/PWData keep their last values; only PSelx/PEnable drop.
- RspRData/RspErr hold their last values after RspValid falls.
- PReady and PRData are ignored outside ACCESS.
- Reset mid-transfer (SETUP or ACCESS): PSelx/PEnable drop immediately, no RspValid is produced, and the pending request is discarded.

Test Plan:
- Write, zero-wait slave: Req write 0xA5 to 0x1234 → SETUP cycle with PSelx=1, PEnable=0, PAddr=0x1234, PWrite=1, PWData=0xA5 → ACCESS 1 cycle → RspValid=1, RspErr=0 three cycles after accept.
- Read with 2 wait states: Req read 0x00FF, slave holds PReady=0 for 2 cycles then PRData=0x3C with PReady=1 → PAddr stable throughout → RspValid=1, RspRData=0x3C five cycles after accept.
- Timeout: TIMEOUT=4, PReady held 0 → ACCESS abandoned after 4 wait cycles → RspValid=1, RspErr=1, RspRData=0 → PSelx=0 in the RspValid cycle.
- Back-to-back with busy filtering: ReqValid held high across 3 requests (writes 0x01/0x02/0x03 to 0x0010/0x0011/0x0012) → accepts only when ReqReady=1 → exactly 3 RspValid pulses 3 cycles apart, no duplicates.
- Reset mid-ACCESS: PResetn low during a waited read → PSelx/PEnable=0 asynchronously, no RspValid → first request after reset completes normally.
- TIMEOUT=0: PReady low for 1000 cycles then high → no abort, RspErr=0, correct RspRData.

Source files
------------

// File: rtl/pep9_apb_master_if.sv
// CPU request/response handshake and APB3 bus signals of the Pep9 memory requester.
interface pep9_apb_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              RspValid;
  logic [DATA_W-1:0] RspRData;
  logic              RspErr;
  logic [ADDR_W-1:0] PAddr;
  logic              PSelx;
  logic              PEnable;
  logic              PWrite;
  logic [DATA_W-1:0] PWData;
  logic              PReady;
  logic [DATA_W-1:0] PRData;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, PReady, PRData,
    output ReqReady, RspValid, RspRData, RspErr,
    output PAddr, PSelx, PEnable, PWrite, PWData
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, PReady, PRData,
    input  ReqReady, RspValid, RspRData, RspErr,
    input  PAddr, PSelx, PEnable, PWrite, PWData
  );
endinterface

// File: rtl/pep9_apb_master.sv
// APB3 requester: turns single-byte Pep9 datapath requests into Setup/Access
// transfers, with a wait-state timeout that aborts a hung slave.
module pep9_apb_master #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               PClk,
  input logic               PResetn,
  pep9_apb_master_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cnt_sat_c;
  logic              timed_out_c;

  assign cnt_sat_c   = (cnt_q == {CNT_W{1'b1}});
  assign timed_out_c = TO_EN && (cnt_q == CNT_W'(TIMEOUT));

  // State and registered bus/response outputs
  always_ff @(posedge PClk or negedge PResetn) begin
    if (!PResetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ReqValid) begin
          state_d  = S_SETUP;
          paddr_d  = bus.ReqAddr;
          pwrite_d = bus.ReqWrite;
          pwdata_d = bus.ReqWData;
          cnt_d    = '0;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.PReady) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRData;
        end else if (timed_out_c) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (!cnt_sat_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Select/enable are registered copies of the phase being entered
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  assign bus.ReqReady = (state_q == S_IDLE);
  assign bus.PAddr    = paddr_q;
  assign bus.PWrite   = pwrite_q;
  assign bus.PWData   = pwdata_q;
  assign bus.PSelx    = psel_q;
  assign bus.PEnable  = penable_q;
  assign bus.RspValid = rsp_valid_q;
  assign bus.RspRData = rsp_rdata_q;
  assign bus.RspErr   = rsp_err_q;

endmodule
